serial_comparator: RTL

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_cmp_pkg.sv | 18 +
 rtl/comparator_1bit.sv | 25 ++
 rtl/serial_comparator.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// ---------------------------------------------------------------------------
// serial_cmp_pkg
//
// Shared definitions for the bit-serial magnitude comparator:
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : controller states (IDLE, COMPARE, DONE)
// ---------------------------------------------------------------------------
package serial_cmp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/comparator_1bit.sv
// ---------------------------------------------------------------------------
// comparator_1bit
//
// Purely combinational single-bit magnitude comparator. Exactly one of the
// three outputs is high for any input pair.
//
// Ports:
//   a_bit, b_bit : the two bits being compared
//   gt           : a_bit > b_bit
//   eq           : a_bit == b_bit
//   lt           : a_bit < b_bit
// ---------------------------------------------------------------------------
module comparator_1bit (
    input  logic a_bit,
    input  logic b_bit,
    output logic gt,
    output logic eq,
    output logic lt
);

    assign gt = a_bit & ~b_bit;
    assign eq = ~(a_bit ^ b_bit);
    assign lt = ~a_bit & b_bit;

endmodule

// File: rtl/serial_comparator.sv
// ---------------------------------------------------------------------------
// serial_comparator
//
// Bit-serial unsigned magnitude comparator. On an accepted start the two
// operands are captured into shift registers and compared MSB-first, one bit
// per clock. The first differing bit ends the comparison early; if all bits
// match the operands are reported equal. The result flags are held until the
// next accepted start.
//
// Ports:
//   clk_in   : clock, rising edge active
//   rst_in   : asynchronous active-high reset
//   start_in : compare request, only honoured in IDLE
//   a_in     : operand A (unsigned, WIDTH bits), captured with start_in
//   b_in     : operand B (unsigned, WIDTH bits), captured with start_in
//   busy_out : high while bits are being compared
//   done_out : one-cycle pulse when a new result is available
//   g_out    : A > B
//   e_out    : A == B
//   l_out    : A < B
// ---------------------------------------------------------------------------
module serial_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             g_out,
    output logic             e_out,
    output logic             l_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic              g_q;
    logic              e_q;
    logic              l_q;
    logic              bit_gt;
    logic              bit_eq;
    logic              bit_lt;
    logic              load_en;
    logic              shift_en;
    logic              latch_diff;
    logic              latch_eq;

    // The current MSBs of the two shift registers are the bits under test.
    comparator_1bit u_bit_cmp (
        .a_bit (a_sr[WIDTH-1]),
        .b_bit (b_sr[WIDTH-1]),
        .gt    (bit_gt),
        .eq    (bit_eq),
        .lt    (bit_lt)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and datapath strobes. A mismatch ends the comparison
    // immediately; a match either advances to the next bit or, when the
    // counter has reached zero, declares the operands equal.
    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        latch_diff = 1'b0;
        latch_eq   = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    load_en    = 1'b1;
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                if (!bit_eq) begin
                    latch_diff = 1'b1;
                    next_state = DONE;
                end else if (bit_cnt != '0) begin
                    shift_en = 1'b1;
                end else begin
                    latch_eq   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand shift registers, bit counter and result flags. Operands are
    // captured only on an accepted start, so later input changes cannot
    // disturb an in-flight comparison.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_sr    <= '0;
            b_sr    <= '0;
            bit_cnt <= '0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            if (load_en) begin
                a_sr    <= a_in;
                b_sr    <= b_in;
                bit_cnt <= CNT_LOAD;
                g_q     <= 1'b0;
                e_q     <= 1'b0;
                l_q     <= 1'b0;
            end
            if (shift_en) begin
                a_sr    <= a_sr << 1;
                b_sr    <= b_sr << 1;
                bit_cnt <= bit_cnt - CNT_W'(1);
            end
            if (latch_diff) begin
                g_q <= bit_gt;
                e_q <= 1'b0;
                l_q <= bit_lt;
            end
            if (latch_eq) begin
                g_q <= 1'b0;
                e_q <= 1'b1;
                l_q <= 1'b0;
            end
        end
    end

    // Status outputs decode straight from the state register, so they carry
    // no combinational path from any input.
    assign busy_out = (state == COMPARE);
    assign done_out = (state == DONE);
    assign g_out    = g_q;
    assign e_out    = e_q;
    assign l_out    = l_q;

endmodule
